key_event: RTL and testbench

//   Classifies one debounced, active-low key into single-cycle events: click,

---
 rtl/key_event.sv | 153 +++++++++++++++
 tb/tb_key_event.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event.sv
// key_event: turns one debounced, active-low key into single-cycle events.
//
// A five-state FSM classifies each press. A shared cycle counter times every
// state and restarts whenever the state changes. All outputs are registered.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous, active-low reset
//   en           block enable; low forces the FSM back to idle
//   key_n        debounced key, 0 = pressed, synchronous to clk
//   pressed      registered copy of the key level (1 while pressed)
//   click        1-cycle pulse: single click, after the release gap expires
//   dclick       1-cycle pulse: second press of a double click released
//   long_press   1-cycle pulse: key held for LONG_CNT cycles
//   repeat_tick  1-cycle pulse: every REPEAT_CNT cycles while still long-held

module key_event #(
    parameter int unsigned CNT_W      = 26,
    parameter int unsigned LONG_CNT   = 25_000_000,
    parameter int unsigned GAP_CNT    = 12_500_000,
    parameter int unsigned REPEAT_CNT = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic key_n,
    output logic pressed,
    output logic click,
    output logic dclick,
    output logic long_press,
    output logic repeat_tick
);

    typedef enum logic [2:0] {
        StIdle,
        StPress1,
        StWait2,
        StPress2,
        StLong
    } state_e;

    // Counter values at which each timed condition is sampled.
    localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] GapLast    = CNT_W'(GAP_CNT - 1);
    localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CNT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_clr;
    logic             key_down;

    logic pressed_q;
    logic click_q, click_d;
    logic dclick_q, dclick_d;
    logic long_q, long_d;
    logic tick_q, tick_d;

    assign key_down = ~key_n;

    // Next-state and event decode. In every state the key transition is
    // tested first, so it wins over a counter expiry on the same edge.
    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        click_d  = 1'b0;
        dclick_d = 1'b0;
        long_d   = 1'b0;
        tick_d   = 1'b0;

        if (!en) begin
            state_d = StIdle;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (key_down) state_d = StPress1;
                end
                StPress1: begin
                    if (!key_down) begin
                        state_d = StWait2;
                    end else if (cnt_q == LongLast) begin
                        state_d = StLong;
                        long_d  = 1'b1;
                    end
                end
                StWait2: begin
                    if (key_down) begin
                        state_d = StPress2;
                    end else if (cnt_q == GapLast) begin
                        state_d = StIdle;
                        click_d = 1'b1;
                    end
                end
                StPress2: begin
                    if (!key_down) begin
                        state_d  = StIdle;
                        dclick_d = 1'b1;
                    end
                end
                StLong: begin
                    if (!key_down) begin
                        state_d = StIdle;
                    end else if (cnt_q == RepeatLast) begin
                        tick_d  = 1'b1;
                        cnt_clr = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Counter restarts on any state change; otherwise counts up and holds at
    // all-ones so a long dwell in idle never wraps.
    always_comb begin
        if (cnt_clr || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            click_q   <= 1'b0;
            dclick_q  <= 1'b0;
            long_q    <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pressed_q <= key_down;
            click_q   <= click_d;
            dclick_q  <= dclick_d;
            long_q    <= long_d;
            tick_q    <= tick_d;
        end
    end

    assign pressed     = pressed_q;
    assign click       = click_q;
    assign dclick      = dclick_q;
    assign long_press  = long_q;
    assign repeat_tick = tick_q;

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: directed scenarios plus randomized key traffic for key_event,
// checked every cycle against a time-stamp based reference model.

module tb_key_event;

    localparam int unsigned CNT_W      = 8;
    localparam int unsigned LONG_CNT   = 20;
    localparam int unsigned GAP_CNT    = 10;
    localparam int unsigned REPEAT_CNT = 5;

    logic clk;
    logic rst_n;
    logic en;
    logic key_n;
    logic pressed;
    logic click;
    logic dclick;
    logic long_press;
    logic repeat_tick;

    key_event #(
        .CNT_W     (CNT_W),
        .LONG_CNT  (LONG_CNT),
        .GAP_CNT   (GAP_CNT),
        .REPEAT_CNT(REPEAT_CNT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .key_n      (key_n),
        .pressed    (pressed),
        .click      (click),
        .dclick     (dclick),
        .long_press (long_press),
        .repeat_tick(repeat_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the phase of the current gesture plus the edge number
    // at which that phase (or the last repeat interval) began.
    localparam int PhIdle   = 0;
    localparam int PhFirst  = 1;
    localparam int PhGap    = 2;
    localparam int PhSecond = 3;
    localparam int PhHeld   = 4;

    int   phase   = PhIdle;
    int   edge_no = 0;
    int   t_start = 0;
    logic exp_pressed = 1'b0;
    logic exp_click   = 1'b0;
    logic exp_dclick  = 1'b0;
    logic exp_long    = 1'b0;
    logic exp_tick    = 1'b0;

    // Observed pulse counts for the current scenario.
    int n_click  = 0;
    int n_dclick = 0;
    int n_long   = 0;
    int n_tick   = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // A condition "held N cycles in this phase" is sampled N edges after the
    // edge that entered the phase.
    task automatic model_edge(input logic e, input logic k);
        int   held;
        logic down;
        down        = !k;
        edge_no     = edge_no + 1;
        held        = edge_no - t_start;
        exp_pressed = down;
        exp_click   = 1'b0;
        exp_dclick  = 1'b0;
        exp_long    = 1'b0;
        exp_tick    = 1'b0;
        if (!e) begin
            phase   = PhIdle;
            t_start = edge_no;
        end else begin
            case (phase)
                PhIdle: if (down) begin
                    phase = PhFirst; t_start = edge_no;
                end
                PhFirst: if (!down) begin
                    phase = PhGap; t_start = edge_no;
                end else if (held == int'(LONG_CNT)) begin
                    phase = PhHeld; t_start = edge_no; exp_long = 1'b1;
                end
                PhGap: if (down) begin
                    phase = PhSecond; t_start = edge_no;
                end else if (held == int'(GAP_CNT)) begin
                    phase = PhIdle; t_start = edge_no; exp_click = 1'b1;
                end
                PhSecond: if (!down) begin
                    phase = PhIdle; t_start = edge_no; exp_dclick = 1'b1;
                end
                default: if (!down) begin
                    phase = PhIdle; t_start = edge_no;
                end else if (held == int'(REPEAT_CNT)) begin
                    t_start = edge_no; exp_tick = 1'b1;
                end
            endcase
        end
    endtask

    task automatic check_outputs();
        check("pressed", pressed, exp_pressed);
        check("click", click, exp_click);
        check("dclick", dclick, exp_dclick);
        check("long_press", long_press, exp_long);
        check("repeat_tick", repeat_tick, exp_tick);
        check("onehot", (int'(click) + int'(dclick) + int'(long_press)
                         + int'(repeat_tick)) <= 1, 1'b1);
        n_click  += int'(click);
        n_dclick += int'(dclick);
        n_long   += int'(long_press);
        n_tick   += int'(repeat_tick);
    endtask

    // Drive inputs at the falling edge, let one rising edge act, check at the
    // next falling edge.
    task automatic step(input logic e, input logic k, input int n);
        for (int i = 0; i < n; i++) begin
            en    = e;
            key_n = k;
            @(posedge clk);
            model_edge(e, k);
            @(negedge clk);
            check_outputs();
        end
    endtask

    task automatic clear_counts();
        n_click  = 0;
        n_dclick = 0;
        n_long   = 0;
        n_tick   = 0;
    endtask

    task automatic model_reset();
        phase       = PhIdle;
        exp_pressed = 1'b0;
        exp_click   = 1'b0;
        exp_dclick  = 1'b0;
        exp_long    = 1'b0;
        exp_tick    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        key_n = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        step(1'b1, 1'b1, 3);

        // 1: single click
        clear_counts();
        step(1'b1, 1'b0, 5);
        step(1'b1, 1'b1, 30);
        check_int("s1_clicks", n_click, 1);
        check_int("s1_dclicks", n_dclick, 0);

        // 2: double click
        clear_counts();
        step(1'b1, 1'b0, 5);
        step(1'b1, 1'b1, 4);
        step(1'b1, 1'b0, 5);
        step(1'b1, 1'b1, 15);
        check_int("s2_dclicks", n_dclick, 1);
        check_int("s2_clicks", n_click, 0);

        // 3: long press with repeats
        clear_counts();
        step(1'b1, 1'b0, 32);
        step(1'b1, 1'b1, 15);
        check_int("s3_long", n_long, 1);
        check_int("s3_ticks", n_tick, 2);
        check_int("s3_clicks", n_click, 0);

        // 4a: release on the last PRESS1 cycle, then let the gap expire
        clear_counts();
        step(1'b1, 1'b0, 20);
        step(1'b1, 1'b1, 25);
        check_int("s4a_long", n_long, 0);
        check_int("s4a_clicks", n_click, 1);

        // 4b: release on the last PRESS1 cycle, press on the last WAIT2 cycle
        clear_counts();
        step(1'b1, 1'b0, 20);
        step(1'b1, 1'b1, 10);
        step(1'b1, 1'b0, 3);
        step(1'b1, 1'b1, 15);
        check_int("s4b_long", n_long, 0);
        check_int("s4b_clicks", n_click, 0);
        check_int("s4b_dclicks", n_dclick, 1);

        // 5a: enable drop during the gap discards the pending click
        clear_counts();
        step(1'b1, 1'b0, 3);
        step(1'b1, 1'b1, 4);
        step(1'b0, 1'b1, 3);
        step(1'b1, 1'b1, 20);
        check_int("s5a_clicks", n_click, 0);

        // 5b: raising enable with the key held starts a press
        clear_counts();
        step(1'b0, 1'b0, 3);
        step(1'b1, 1'b0, 5);
        step(1'b1, 1'b1, 15);
        check_int("s5b_clicks", n_click, 1);

        // 6: asynchronous reset while long-held
        clear_counts();
        step(1'b1, 1'b0, 25);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        key_n = 1'b1;
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        clear_counts();
        step(1'b1, 1'b1, 15);
        check_int("s6_pulses", n_click + n_dclick + n_long + n_tick, 0);

        // Randomized key traffic with occasional enable drops
        for (int seg = 0; seg < 60; seg++) begin
            logic e;
            logic k;
            e = ($urandom_range(0, 7) != 0);
            k = logic'($urandom_range(0, 1));
            step(e, k, int'($urandom_range(1, 26)));
        end
        step(1'b1, 1'b1, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
